// File: rtl/clk_div_req_arbiter.sv
// Round-robin arbiter that serialises divider-change requests from several
// agents onto one div/valid/ready divider reconfiguration port.

module clk_div_req_norm #(
    parameter int W = 4
) (
    input  logic [W-1:0] div,
    output logic [W-1:0] div_norm
);
    // 0 and 1 give the same output frequency; collapse to 1 so no needless change.
    assign div_norm = (div == '0) ? W'(1) : div;
endmodule

module clk_div_req_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int DIV_VALUE_WIDTH   = 4,
    parameter int DEFAULT_DIV_VALUE = 1,
    parameter int TIMEOUT_CYCLES    = 256
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ*DIV_VALUE_WIDTH-1:0] req_div_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [DIV_VALUE_WIDTH-1:0]         div_o,
    output logic                               div_valid_o,
    input  logic                               div_ready_i,
    output logic [DIV_VALUE_WIDTH-1:0]         cur_div_o,
    output logic                               busy_o,
    output logic                               timeout_o,
    input  logic                               timeout_clr_i
);
    localparam int W  = DIV_VALUE_WIDTH;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] DEF_DIV = (DEFAULT_DIV_VALUE == 0) ? W'(1) : W'(DEFAULT_DIV_VALUE);

    if (DEFAULT_DIV_VALUE < 0 || DEFAULT_DIV_VALUE >= (1 << DIV_VALUE_WIDTH)) begin : g_bad_default
        $error("DEFAULT_DIV_VALUE does not fit in DIV_VALUE_WIDTH bits");
    end
    if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_num_req
        $error("NUM_REQ must be 1..16");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2} state_e;

    state_e                    state_q;
    logic [IW-1:0]             rr_q, win_q, win_idx;
    logic [W-1:0]              val_q, cur_div_q, div_q, win_val;
    logic                      div_valid_q, timeout_q, any_req;
    logic [NUM_REQ-1:0]        req_ready_q;
    logic [CW-1:0]             cnt_q;
    logic [IW:0]               scan_idx;
    logic [NUM_REQ-1:0][W-1:0] norm;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        clk_div_req_norm #(.W(W)) u_norm (
            .div      (req_div_i[i*W +: W]),
            .div_norm (norm[i])
        );
    end

    // Scan offsets from high to low so the lowest offset from rr_q wins last.
    always_comb begin
        any_req  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_q} + (IW+1)'(k);
            if (scan_idx >= (IW+1)'(NUM_REQ)) scan_idx = scan_idx - (IW+1)'(NUM_REQ);
            if (req_valid_i[scan_idx[IW-1:0]]) begin
                any_req = 1'b1;
                win_idx = scan_idx[IW-1:0];
            end
        end
    end

    assign win_val = norm[win_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            win_q       <= '0;
            val_q       <= DEF_DIV;
            cur_div_q   <= DEF_DIV;
            div_q       <= DEF_DIV;
            div_valid_q <= 1'b0;
            req_ready_q <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            req_ready_q <= '0;
            if (timeout_clr_i) timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (any_req) begin
                        win_q <= win_idx;
                        val_q <= win_val;
                        if (win_val == cur_div_q) begin
                            state_q     <= ACK;
                            req_ready_q <= NUM_REQ'(1) << win_idx;
                        end else begin
                            state_q     <= REQ;
                            div_q       <= win_val;
                            div_valid_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (div_ready_i) begin
                        cur_div_q   <= val_q;
                        div_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ACK;
                        req_ready_q <= NUM_REQ'(1) << win_q;
                    end else begin
                        if (cnt_q != CW'(TIMEOUT_CYCLES)) cnt_q <= cnt_q + CW'(1);
                        // Placed after the clear so a coincident set wins.
                        if (cnt_q >= CW'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
                    end
                end
                ACK: begin
                    rr_q    <= (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
                    state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    div_valid_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign div_o       = div_q;
    assign div_valid_o = div_valid_q;
    assign cur_div_o   = cur_div_q;
    assign busy_o      = (state_q != IDLE);
    assign timeout_o   = timeout_q;
endmodule

// File: doc/clk_div_req_arbiter.md
Name: clk_div_req_arbiter

Overview:
- Shares one runtime-configurable integer clock divider between NUM_REQ independent requesters, e.g. power-management agents or software CSR ports.
- Arbitrates divider-change requests round-robin and drives the divider's div/valid/ready reconfiguration handshake.
- Returns a one-cycle grant to the winning requester.
- Tracks the currently applied divider value and flags divider handshakes that stall too long.

Parameters:
- NUM_REQ, 4, number of requesters (1..16).
- DIV_VALUE_WIDTH, 4, width of a divider value; must match the divider instance.
- DEFAULT_DIV_VALUE, 1, divider value after reset; must equal the divider's own reset value. Elaboration error if it is not representable in DIV_VALUE_WIDTH bits.
- TIMEOUT_CYCLES, 256, number of REQ cycles without div_ready_i before timeout_o is set (at least 2).

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- req_valid_i, in, NUM_REQ, per-requester change request.
- req_div_i, in, NUM_REQ*DIV_VALUE_WIDTH, requested divider value; slice i belongs to requester i.
- req_ready_o, out, NUM_REQ, one-hot grant pulse; the request is complete.
- div_o, out, DIV_VALUE_WIDTH, value driven to the divider's div_i.
- div_valid_o, out, 1, to the divider's div_valid_i.
- div_ready_i, in, 1, from the divider's div_ready_o.
- cur_div_o, out, DIV_VALUE_WIDTH, last divider value the divider has accepted.
- busy_o, out, 1, FSM not in IDLE.
- timeout_o, out, 1, sticky handshake-stall flag.
- timeout_clr_i, in, 1, clears timeout_o.

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready_o=0.
  - div_valid_o=0, div_o=DEFAULT_DIV_VALUE (normalised).
  - cur_div_o=DEFAULT_DIV_VALUE (normalised).
  - busy_o=0, timeout_o=0.
  - Round-robin pointer rr_q=0.
  - Timeout counter = 0.
- Normalisation: a requested value of 0 is mapped to 1 before comparison, latching and forwarding. The divider treats 0 and 1 as the same frequency, so normalising avoids needless clock-gating transitions. div_o never carries 0.
- Requester rules:
  - Once asserted, req_valid_i[i] and its req_div_i slice are held stable until req_ready_o[i]=1.
  - Deasserting early is a protocol violation. The latched request still completes and the grant pulse is still issued.
- Arbitration, in IDLE only:
  - The winner is the first asserted req_valid_i index at or after rr_q, wrapping modulo NUM_REQ.
  - The winner index and its normalised value are registered into win_q and val_q.
  - Next state is ACK if val_q equals cur_div (fast path), otherwise REQ.
- REQ state:
  - div_valid_o=1, div_o=val_q, both registered outputs.
  - div_valid_o stays high until div_ready_i is sampled high. Timeout never drops valid, per the divider's protocol.
  - On div_ready_i=1: cur_div <= val_q, div_valid_o <= 0, next state ACK.
- ACK state:
  - req_ready_o[win_q]=1 for exactly one cycle.
  - rr_q <= (win_q+1) mod NUM_REQ.
  - Next state IDLE.
  - New requests are not sampled in ACK, so the granted requester's valid can drop without re-arbitration.
- Latency:
  - Fast path: req_valid_i first seen at edge N gives the grant in cycle N+1.
  - Slow path: div_valid_o is high from cycle N+1. With div_ready_i high in cycle K, the grant is in cycle K+1.
  - Minimum request-to-request spacing is 2 cycles.
- Timeout:
  - Counter increments each cycle in REQ and clears on leaving REQ.
  - When it reaches TIMEOUT_CYCLES, timeout_o is set. Counting saturates.
  - timeout_o stays set until timeout_clr_i. If clear and set happen in the same cycle, set wins.
- Simultaneous events:
  - Multiple valids are resolved purely by rr_q; the same requester cannot win twice while another is waiting.
  - A requester whose value equals cur_div still takes an arbitration slot.
- busy_o = (state != IDLE).
- cur_div_o updates only on an accepted handshake.
- Reset mid-operation: all state returns to reset values in the next cycle and pending requests are dropped without grant. rst_i must be asserted together with the divider's reset; dropping div_valid_o mid-handshake otherwise violates the divider protocol.
- Unreachable state encodings go to IDLE.

Test Plan:
1. Reset, then req_valid_i=0001 with req_div_i[0]=1 (equals default) -> div_valid_o never rises; req_ready_o=0001 exactly one cycle after valid is seen; cur_div_o=1.
2. Req 0 asks div=6; divider model asserts ready 5 cycles after valid -> div_o=6 and div_valid_o=1 held all 5 cycles; cur_div_o=6 on acceptance; grant one cycle later.
3. All four requesters valid at once with values 2, 3, 4, 5 -> grants in order 0,1,2,3; cur_div_o ends at 5; exactly four divider handshakes.
4. Request div=0 while cur_div_o=1 -> fast-path grant, no handshake. Then div=0 while cur_div_o=4 -> div_o=1, never 0.
5. TIMEOUT_CYCLES=8, ready withheld 20 cycles -> timeout_o rises after 8 REQ cycles while div_valid_o stays 1. Handshake completes normally. timeout_clr_i clears the flag; clear and set in the same cycle keeps it set.
6. Assert rst_i during REQ -> next cycle div_valid_o=0, busy_o=0, cur_div_o=DEFAULT, rr_q=0; no grant issued.
